// File: rtl/seq_mul_ctrl.sv
// Shift-add unsigned multiplier sequencer driving an external WIDTH-bit adder.
// Optional SEQ_MUL_ZERO_BYPASS_EN: zero operands skip straight to DONE.
module seq_mul_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_c,
    input  logic [WIDTH:0]     add_s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             zero_op;
    logic             accept;

    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign accept = (state == IDLE) && in_valid;

`ifdef SEQ_MUL_ZERO_BYPASS_EN
    assign zero_op = (in_a == '0) || (in_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = zero_op ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and adder drive; the adder sees zeros outside CALC
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_c     = 1'b0;
        out_p     = '0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            CALC: begin
                busy  = 1'b1;
                add_a = acc_hi;
                add_b = acc_lo[0] ? mcand : '0;
            end
            DONE: begin
                out_valid = 1'b1;
                out_p     = {acc_hi, acc_lo};
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Operand load on accept, one add/shift per CALC cycle; the adder
    // carry lands in the top bit of acc_hi so overflowing sums survive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= in_a;
            acc_hi <= '0;
            acc_lo <= zero_op ? '0 : in_b;
            cnt    <= '0;
        end else if (state == CALC) begin
            {acc_hi, acc_lo} <= {add_s, acc_lo[WIDTH-1:1]};
            cnt              <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Randomized and directed bench for seq_mul_ctrl with a behavioural adder
// and a product/latency reference computed from plain arithmetic.
module tb_seq_mul_ctrl;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic           busy;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_c;
    logic [W:0]     add_s;

    int errs;
    int checks;

    seq_mul_ctrl #(.WIDTH(W), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .add_s     (add_s)
    );

    // External adder: plain unsigned addition
    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int a, input int b);
`ifdef SEQ_MUL_ZERO_BYPASS_EN
        if (a == 0 || b == 0) return 0;
`endif
        return W;
    endfunction

    // One job: caller is at a negedge with the DUT idle
    task automatic job(input int a, input int b, input int stall,
                       input bit both);
        int lat;
        int bcnt;
        logic [2*W-1:0] hold;
        chk("idle_ready", in_ready, 1);
        chk("idle_add_a", add_a, 0);
        chk("idle_add_b", add_b, 0);
        in_valid = 1'b1;
        in_a     = W'(a);
        in_b     = W'(b);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat(a, b));
        chk("busy_cycles", bcnt, exp_lat(a, b));
        chk("product", out_p, a * b);
        chk("done_busy", busy, 0);
        chk("done_add_a", add_a, 0);
        hold = out_p;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_p", out_p, hold);
            chk("stall_ready", in_ready, 0);
        end
        in_valid  = both;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("ack_valid", out_valid, 0);
        chk("ack_ready", in_ready, 1);
    endtask

    initial begin
        errs      = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_p", out_p, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);

        job(13, 11, 0, 1'b0);
        job(15, 15, 0, 1'b0);
        job(7, 9, 5, 1'b1);
        job(2, 3, 0, 1'b0);
        job(0, 9, 0, 1'b0);
        job(9, 0, 2, 1'b0);

        // Reset after the second iteration discards the job
        in_valid = 1'b1;
        in_a     = 4'd13;
        in_b     = 4'd11;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_valid", out_valid, 0);
            @(negedge clk);
        end
        job(5, 6, 0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                job(a, b, 0, 1'($urandom));
            end
        end

        for (int i = 0; i < 30; i++) begin
            job(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                int'($urandom_range(4, 0)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
